// File: rtl/foc_loopback_checker_if.sv
// Bundle between the FOC codec loopback and its self-checker: the words under test in, the check results and statistics out.
interface foc_loopback_checker_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             clr;
  logic             chk_valid;
  logic             chk_pass;
  logic [CNT_W-1:0] word_count;
  logic [CNT_W-1:0] err_count;
  logic             err_sticky;
  logic [WIDTH-1:0] first_err_exp;
  logic [WIDTH-1:0] first_err_got;

  modport master (
    output in_valid, data_in, data_out, clr,
    input  chk_valid, chk_pass, word_count, err_count, err_sticky,
           first_err_exp, first_err_got
  );

  modport slave (
    input  in_valid, data_in, data_out, clr,
    output chk_valid, chk_pass, word_count, err_count, err_sticky,
           first_err_exp, first_err_got
  );
endinterface

// File: rtl/foc_loopback_checker.sv
// Delays each word sent into the FOC codec by the codec latency and compares it with the decoded output.
// It keeps saturating pass/fail counters and captures the first mismatch.
module foc_loopback_checker #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 16
) (
  input logic                  clk,
  input logic                  rst,
  foc_loopback_checker_if.slave bus
);

  localparam int unsigned      TAIL    = LATENCY - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             vld_q  [LATENCY];
  logic [WIDTH-1:0] word_q [LATENCY];

  logic tail_vld_c;
  logic match_c;

  assign tail_vld_c = vld_q[TAIL];
  assign match_c    = (bus.data_out == word_q[TAIL]);

  // Delay line of {valid, word}; reset drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < int'(LATENCY); k++) begin
        vld_q[k]  <= 1'b0;
        word_q[k] <= '0;
      end
    end else begin
      vld_q[0]  <= bus.in_valid;
      word_q[0] <= bus.data_in;
      for (int k = 1; k < int'(LATENCY); k++) begin
        vld_q[k]  <= vld_q[k-1];
        word_q[k] <= word_q[k-1];
      end
    end
  end

  // The result pulse ignores clr; clr only clears the statistics.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.chk_valid <= 1'b0;
      bus.chk_pass  <= 1'b0;
    end else begin
      bus.chk_valid <= tail_vld_c;
      bus.chk_pass  <= match_c;
    end
  end

  // Saturating counters and first-failure capture; clr beats a coincident compare.
  always_ff @(posedge clk) begin
    if (!rst || bus.clr) begin
      bus.word_count    <= '0;
      bus.err_count     <= '0;
      bus.err_sticky    <= 1'b0;
      bus.first_err_exp <= '0;
      bus.first_err_got <= '0;
    end else if (tail_vld_c) begin
      if (bus.word_count != CNT_MAX) begin
        bus.word_count <= bus.word_count + CNT_W'(1);
      end
      if (!match_c) begin
        if (bus.err_count != CNT_MAX) begin
          bus.err_count <= bus.err_count + CNT_W'(1);
        end
        if (!bus.err_sticky) begin
          bus.err_sticky    <= 1'b1;
          bus.first_err_exp <= word_q[TAIL];
          bus.first_err_got <= bus.data_out;
        end
      end
    end
  end

endmodule
